puf_eval_sequencer: RTL

Controller that sequences a bank of NUM_PUF delay-PUF instances. The instances share one challenge bus, one run line and one PUF reset.
- Per challenge: pulses the PUF reset, applies the challenge, asserts run, waits a settle window, then samples all result bits.
- Runs RESP_W/NUM_PUF consecutive challenges (seed, seed+1, …) and packs the results into one response word readable over the logic analyzer.
- Sits between the LA control bits and the PUF bank, replacing direct LA drive of reset, run and challenge.

---
 rtl/puf_eval_sequencer_pkg.sv | 23 ++
 rtl/puf_eval_sequencer_if.sv | 31 +++
 rtl/puf_majority3.sv | 17 +
 rtl/puf_eval_sequencer.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/puf_eval_sequencer_pkg.sv
// Shared types and constants for the PUF evaluation sequencer.
// Optional feature macro: PUF_VOTE_EN (three passes per challenge, majority vote).
package puf_seq_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StPrst,
        StArm,
        StSettle,
        StSample,
        StDone
    } seq_state_e;

    // Cycles the PUF bank reset is held high per pass.
    localparam int unsigned PRST_CYC = 2;

`ifdef PUF_VOTE_EN
    localparam int unsigned VOTE_PASSES = 3;
`else
    localparam int unsigned VOTE_PASSES = 1;
`endif

endpackage

// File: rtl/puf_eval_sequencer_if.sv
// Control/response bundle between the sequencer, its LA-side driver and the PUF bank.
// Signal suffixes are from the sequencer's point of view.
interface puf_eval_sequencer_if #(
    parameter int unsigned NUM_PUF = 4,
    parameter int unsigned CHAL_W  = 8,
    parameter int unsigned RESP_W  = 32
);
    logic                start_i;
    logic                abort_i;
    logic [CHAL_W-1:0]   seed_i;
    logic [NUM_PUF-1:0]  puf_res_i;
    logic                puf_rst_o;
    logic                puf_run_o;
    logic [CHAL_W-1:0]   puf_chal_o;
    logic [RESP_W-1:0]   resp_o;
    logic                resp_valid_o;
    logic                busy_o;
    logic                done_o;

    // Sequencer side.
    modport slave (
        input  start_i, abort_i, seed_i, puf_res_i,
        output puf_rst_o, puf_run_o, puf_chal_o, resp_o, resp_valid_o, busy_o, done_o
    );

    // Driver / PUF bank side.
    modport master (
        output start_i, abort_i, seed_i, puf_res_i,
        input  puf_rst_o, puf_run_o, puf_chal_o, resp_o, resp_valid_o, busy_o, done_o
    );
endinterface

// File: rtl/puf_majority3.sv
// Bitwise 2-of-3 majority vote over three PUF samples.
// Only compiled when PUF_VOTE_EN is defined; the default build has no vote logic.
`ifdef PUF_VOTE_EN
module puf_majority3 #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] c_i,
    output logic [WIDTH-1:0] y_o
);
    // Each output bit follows whichever value at least two samples agree on.
    always_comb begin
        y_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
    end
endmodule
`endif

// File: rtl/puf_eval_sequencer.sv
// Sequences a bank of delay-PUF instances: reset pulse, run/settle, sample, for
// RESP_W/NUM_PUF consecutive challenges, packing the results into one response word.
// Optional feature macro: PUF_VOTE_EN (three passes per challenge, majority vote).
module puf_eval_sequencer
    import puf_seq_pkg::*;
#(
    parameter int unsigned NUM_PUF    = 4,
    parameter int unsigned CHAL_W     = 8,
    parameter int unsigned RESP_W     = 32,
    parameter int unsigned SETTLE_CYC = 16
) (
    input logic                   wb_clk_i,
    input logic                   wb_rst_n_i,
    puf_eval_sequencer_if.slave   bus
);
    localparam int unsigned NUM_CHAL = RESP_W / NUM_PUF;
    localparam int unsigned CNT_W    = $clog2(NUM_CHAL + 1);
    localparam int unsigned TMR_MAX  = (SETTLE_CYC > PRST_CYC) ? SETTLE_CYC : PRST_CYC;
    localparam int unsigned TMR_W    = $clog2(TMR_MAX + 1);

    seq_state_e          state_q;
    logic [CHAL_W-1:0]   chal_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [TMR_W-1:0]    tmr_q;
    logic [RESP_W-1:0]   resp_q;
    logic                resp_valid_q;
    logic                puf_rst_q;
    logic                puf_run_q;
    logic                busy_q;
    logic                done_q;

    logic                last_pass;
    logic [NUM_PUF-1:0]  sample_bits;

`ifdef PUF_VOTE_EN
    logic [1:0]          pass_q;
    logic [NUM_PUF-1:0]  vote0_q;
    logic [NUM_PUF-1:0]  vote1_q;
    logic [NUM_PUF-1:0]  voted;

    // Third pass samples directly from the bank; the first two come from registers.
    puf_majority3 #(
        .WIDTH (NUM_PUF)
    ) u_vote (
        .a_i (vote0_q),
        .b_i (vote1_q),
        .c_i (bus.puf_res_i),
        .y_o (voted)
    );

    // Vote result is only shifted in on the final pass of a challenge.
    always_comb begin
        last_pass   = (pass_q == 2'(VOTE_PASSES - 1));
        sample_bits = voted;
    end
`else
    // Single pass per challenge: every sample is shifted in directly.
    always_comb begin
        last_pass   = 1'b1;
        sample_bits = bus.puf_res_i;
    end
`endif

    // Sequencer FSM with registered outputs; abort overrides everything except reset.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q      <= StIdle;
            chal_q       <= '0;
            cnt_q        <= '0;
            tmr_q        <= '0;
            resp_q       <= '0;
            resp_valid_q <= 1'b0;
            puf_rst_q    <= 1'b0;
            puf_run_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef PUF_VOTE_EN
            pass_q       <= '0;
            vote0_q      <= '0;
            vote1_q      <= '0;
`endif
        end else if (bus.abort_i) begin
            state_q      <= StIdle;
            tmr_q        <= '0;
            resp_valid_q <= 1'b0;
            puf_rst_q    <= 1'b0;
            puf_run_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef PUF_VOTE_EN
            pass_q       <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.start_i) begin
                        chal_q       <= bus.seed_i;
                        resp_q       <= '0;
                        resp_valid_q <= 1'b0;
                        cnt_q        <= '0;
                        tmr_q        <= '0;
                        puf_rst_q    <= 1'b1;
                        busy_q       <= 1'b1;
                        state_q      <= StPrst;
`ifdef PUF_VOTE_EN
                        pass_q       <= '0;
`endif
                    end
                end
                StPrst: begin
                    if (tmr_q == TMR_W'(PRST_CYC - 1)) begin
                        tmr_q     <= '0;
                        puf_rst_q <= 1'b0;
                        puf_run_q <= 1'b1;
                        state_q   <= StArm;
                    end else begin
                        tmr_q <= tmr_q + 1'b1;
                    end
                end
                StArm: begin
                    tmr_q   <= '0;
                    state_q <= StSettle;
                end
                StSettle: begin
                    if (tmr_q == TMR_W'(SETTLE_CYC - 1)) begin
                        tmr_q   <= '0;
                        state_q <= StSample;
                    end else begin
                        tmr_q <= tmr_q + 1'b1;
                    end
                end
                StSample: begin
                    puf_run_q <= 1'b0;
                    tmr_q     <= '0;
`ifdef PUF_VOTE_EN
                    if (pass_q == 2'd0) begin
                        vote0_q <= bus.puf_res_i;
                    end
                    if (pass_q == 2'd1) begin
                        vote1_q <= bus.puf_res_i;
                    end
                    pass_q <= last_pass ? 2'd0 : pass_q + 1'b1;
`endif
                    if (last_pass) begin
                        // Earlier challenges migrate toward the MSBs as later ones shift in.
                        resp_q <= {resp_q[RESP_W-NUM_PUF-1:0], sample_bits};
                        chal_q <= chal_q + 1'b1;
                        cnt_q  <= cnt_q + 1'b1;
                        if (cnt_q == CNT_W'(NUM_CHAL - 1)) begin
                            state_q <= StDone;
                        end else begin
                            puf_rst_q <= 1'b1;
                            state_q   <= StPrst;
                        end
                    end else begin
                        puf_rst_q <= 1'b1;
                        state_q   <= StPrst;
                    end
                end
                StDone: begin
                    done_q       <= 1'b1;
                    resp_valid_q <= 1'b1;
                    busy_q       <= 1'b0;
                    state_q      <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.puf_rst_o    = puf_rst_q;
    assign bus.puf_run_o    = puf_run_q;
    assign bus.puf_chal_o   = chal_q;
    assign bus.resp_o       = resp_q;
    assign bus.resp_valid_o = resp_valid_q;
    assign bus.busy_o       = busy_q;
    assign bus.done_o       = done_q;

endmodule
